// File: rtl/code_fetch_ctrl.sv
// 8051 program-memory fetch controller: drives the single-port synchronous ROM,
// keeps a small prefetch queue for the decoder and arbitrates MOVC table reads.
module code_fetch_ctrl #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    input  logic                     jump,
    input  logic [ADDRESS_WIDTH-1:0] jump_addr,
    output logic                     op_valid,
    output logic [DATA_WIDTH-1:0]    op_byte,
    output logic [ADDRESS_WIDTH-1:0] op_pc,
    input  logic                     op_ready,
    input  logic                     movc_req,
    input  logic [ADDRESS_WIDTH-1:0] movc_addr,
    output logic                     movc_ack,
    output logic [DATA_WIDTH-1:0]    movc_data
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // What the ROM is returning this cycle, i.e. what was issued last cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_FETCH,
        SLOT_MOVC
    } slot_t;

    slot_t                    slot, slot_next;
    logic [ADDRESS_WIDTH-1:0] fetch_pc, fetch_pc_next;
    logic [ADDRESS_WIDTH-1:0] inflight_pc, inflight_pc_next;

    logic [DATA_WIDTH-1:0]    q_byte [QUEUE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0]         head, tail;
    logic [CNT_W-1:0]         count, occupancy;
    logic [DATA_WIDTH-1:0]    last_byte, movc_hold;
    logic [ADDRESS_WIDTH-1:0] last_pc;
    logic                     push, pop;

    assign occupancy = count + {{(CNT_W-1){1'b0}}, slot == SLOT_FETCH};
    assign push      = (slot == SLOT_FETCH) && !jump;
    assign pop       = op_valid && op_ready && !jump;

    assign op_valid  = (count != '0);
    assign op_byte   = op_valid ? q_byte[head] : last_byte;
    assign op_pc     = op_valid ? q_pc[head]   : last_pc;
    assign movc_ack  = (slot == SLOT_MOVC);
    assign movc_data = movc_ack ? rom_data : movc_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot        <= SLOT_IDLE;
            fetch_pc    <= '0;
            inflight_pc <= '0;
        end else begin
            slot        <= slot_next;
            fetch_pc    <= fetch_pc_next;
            inflight_pc <= inflight_pc_next;
        end
    end

    // One ROM access per cycle: jump, then MOVC, then prefetch; idle reads are dropped.
    always_comb begin
        slot_next        = SLOT_IDLE;
        fetch_pc_next    = fetch_pc;
        inflight_pc_next = inflight_pc;
        rom_addr         = fetch_pc;
        if (jump) begin
            rom_addr         = jump_addr;
            slot_next        = SLOT_FETCH;
            inflight_pc_next = jump_addr;
            fetch_pc_next    = jump_addr + 1'b1;
        end else if (movc_req && slot != SLOT_MOVC) begin
            rom_addr  = movc_addr;
            slot_next = SLOT_MOVC;
        end else if (occupancy < CNT_W'(QUEUE_DEPTH)) begin
            slot_next        = SLOT_FETCH;
            inflight_pc_next = fetch_pc;
            fetch_pc_next    = fetch_pc + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            last_byte <= '0;
            last_pc   <= '0;
            movc_hold <= '0;
        end else begin
            if (op_valid) begin
                last_byte <= q_byte[head];
                last_pc   <= q_pc[head];
            end
            if (movc_ack) begin
                movc_hold <= rom_data;
            end
            if (jump) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_byte[tail] <= rom_data;
            q_pc[tail]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_code_fetch_ctrl.sv
// Bench for code_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a byte-stream / MOVC-transaction reference model.
module tb_code_fetch_ctrl;

    localparam int AW         = 16;
    localparam int DW         = 8;
    localparam int QD         = 4;
    localparam int MOVC_LIMIT = 40;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic          op_valid;
    logic [DW-1:0] op_byte;
    logic [AW-1:0] op_pc;
    logic          op_ready;
    logic          movc_req;
    logic [AW-1:0] movc_addr;
    logic          movc_ack;
    logic [DW-1:0] movc_data;

    logic [DW-1:0] rom [0:65535];

    code_fetch_ctrl #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .QUEUE_DEPTH  (QD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .jump     (jump),
        .jump_addr(jump_addr),
        .op_valid (op_valid),
        .op_byte  (op_byte),
        .op_pc    (op_pc),
        .op_ready (op_ready),
        .movc_req (movc_req),
        .movc_addr(movc_addr),
        .movc_ack (movc_ack),
        .movc_data(movc_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    int checks = 0;
    int errors = 0;

    // Reference model: the decoder must see the byte stream rom[target], rom[target+1], ...
    logic [AW-1:0] exp_pc, last_pc, movc_a;
    logic [DW-1:0] last_byte, last_movc;
    bit            hist1, hist2, restart, expect_stream;
    bit            movc_pend, movc_done, movc_cool;
    int            movc_wait;
    logic [AW-1:0] wrap_exp [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic raise_movc(input logic [AW-1:0] addr);
        movc_req  = 1'b1;
        movc_addr = addr;
        movc_a    = addr;
        movc_pend = 1'b1;
        movc_wait = 0;
    endtask

    task automatic cycle();
        bit            redirect;
        logic [AW-1:0] target;
        @(negedge clock);
        redirect = jump || restart;
        target   = jump ? jump_addr : '0;
        if (hist1) check_eq("flush_valid", 32'(op_valid), 32'(0));
        else if (hist2 || expect_stream) check_eq("head_valid", 32'(op_valid), 32'(1));
        if (op_valid) begin
            check_eq("head_pc", 32'(op_pc), 32'(exp_pc));
            check_eq("head_byte", 32'(op_byte), 32'(rom[exp_pc]));
            last_pc   = exp_pc;
            last_byte = rom[exp_pc];
        end else begin
            check_eq("hold_pc", 32'(op_pc), 32'(last_pc));
            check_eq("hold_byte", 32'(op_byte), 32'(last_byte));
        end
        if (redirect) exp_pc = target;
        else if (op_valid && op_ready) exp_pc = exp_pc + 1'b1;
        hist2   = hist1;
        hist1   = redirect;
        restart = 1'b0;
        if (movc_pend) begin
            if (movc_ack) begin
                check_eq("movc_data", 32'(movc_data), 32'(rom[movc_a]));
                last_movc = rom[movc_a];
                movc_pend = 1'b0;
                movc_done = 1'b1;
            end else begin
                check_eq("movc_hold", 32'(movc_data), 32'(last_movc));
                movc_wait++;
                if (movc_wait > MOVC_LIMIT) begin
                    check_eq("movc_timeout", 32'(movc_wait), 32'(MOVC_LIMIT));
                    movc_pend = 1'b0;
                    movc_done = 1'b1;
                end
            end
        end else begin
            check_eq("movc_spurious", 32'(movc_ack), 32'(0));
            check_eq("movc_hold", 32'(movc_data), 32'(last_movc));
        end
        @(posedge clock);
        #1;
        if (movc_done) begin
            movc_req  = 1'b0;
            movc_done = 1'b0;
            movc_cool = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        jump      = 1'b0;
        movc_req  = 1'b0;
        movc_pend = 1'b0;
        movc_done = 1'b0;
        movc_cool = 1'b0;
        #2;
        check_eq("rst_valid", 32'(op_valid), 32'(0));
        check_eq("rst_byte", 32'(op_byte), 32'(0));
        check_eq("rst_pc", 32'(op_pc), 32'(0));
        check_eq("rst_ack", 32'(movc_ack), 32'(0));
        check_eq("rst_movc_data", 32'(movc_data), 32'(0));
        check_eq("rst_rom_addr", 32'(rom_addr), 32'(0));
        @(posedge clock);
        #1;
        reset         = 1'b0;
        exp_pc        = '0;
        last_pc       = '0;
        last_byte     = '0;
        last_movc     = '0;
        hist1         = 1'b0;
        hist2         = 1'b0;
        restart       = 1'b1;
        expect_stream = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        jump      = 1'b0;
        jump_addr = '0;
        op_ready  = 1'b0;
        movc_req  = 1'b0;
        movc_addr = '0;
        wrap_exp  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h02; rom[1] = 8'h00; rom[2] = 8'h10;
        rom[3] = 8'hE4; rom[4] = 8'hF5; rom[5] = 8'h90;
        repeat (2) @(posedge clock);
        #1;

        // Startup after reset release: first byte at the head on cycle 2
        op_ready = 1'b1;
        do_reset();
        cycle();
        cycle();
        expect_stream = 1'b1;
        repeat (6) cycle();

        // Stalled decoder fills the queue without overflow, then drains gap-free
        op_ready = 1'b0;
        do_reset();
        repeat (10) cycle();
        op_ready      = 1'b1;
        expect_stream = 1'b1;
        repeat (12) cycle();

        // Jump with the queue filling and a fetch in flight
        op_ready = 1'b0;
        do_reset();
        repeat (4) cycle();
        jump      = 1'b1;
        jump_addr = 16'h0100;
        op_ready  = 1'b1;
        cycle();
        jump = 1'b0;
        cycle();
        #2 check_eq("jump_head_pc", 32'(op_pc), 32'h0100);
        expect_stream = 1'b1;
        repeat (8) cycle();

        // MOVC steals one ROM slot during prefetch
        expect_stream = 1'b0;
        raise_movc(16'h0200);
        #2 check_eq("movc_issue_addr", 32'(rom_addr), 32'h0200);
        cycle();
        #2 check_eq("movc_ack_next", 32'(movc_ack), 32'(1));
        cycle();
        repeat (6) cycle();

        // Jump and MOVC in the same cycle: jump first, MOVC next
        jump      = 1'b1;
        jump_addr = 16'h0300;
        raise_movc(16'h0210);
        #2 check_eq("jm_rom_addr_jump", 32'(rom_addr), 32'h0300);
        cycle();
        jump = 1'b0;
        #2 check_eq("jm_rom_addr_movc", 32'(rom_addr), 32'h0210);
        check_eq("jm_no_ack", 32'(movc_ack), 32'(0));
        cycle();
        #2 check_eq("jm_ack", 32'(movc_ack), 32'(1));
        cycle();
        cycle();

        // Jump while a MOVC is in flight: ack still delivered
        raise_movc(16'h0220);
        #2 check_eq("mj_issue", 32'(rom_addr), 32'h0220);
        cycle();
        jump      = 1'b1;
        jump_addr = 16'h0400;
        #2 check_eq("mj_ack", 32'(movc_ack), 32'(1));
        check_eq("mj_rom_addr", 32'(rom_addr), 32'h0400);
        cycle();
        jump = 1'b0;
        repeat (6) cycle();

        // Address wrap after a jump near the top of memory
        op_ready  = 1'b1;
        jump      = 1'b1;
        jump_addr = 16'hFFFE;
        cycle();
        jump = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            #2 check_eq("wrap_pc", 32'(op_pc), 32'(wrap_exp[i]));
            cycle();
        end

        // Randomized traffic with occasional asynchronous mid-run resets
        for (int n = 0; n < 4000; n++) begin
            if (n % 1000 == 500) begin
                #1;
                do_reset();
            end
            jump      = ($urandom_range(0, 19) == 0);
            jump_addr = ($urandom_range(0, 3) == 0) ? AW'(32'hFFFC + $urandom_range(0, 3))
                                                    : AW'($urandom);
            op_ready  = ($urandom_range(0, 3) != 0);
            if (!movc_req && !movc_pend) begin
                if (movc_cool) movc_cool = 1'b0;
                else if ($urandom_range(0, 5) == 0) raise_movc(AW'($urandom));
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
